fifo_wptr_full: RTL and testbench
=================================

Name: fifo_wptr_full

Overview:
- Write-domain control half of the asynchronous FIFO. It is the counterpart to the read-side logic that drives rd_en_i, rdata_o, empty_o and error_o.
- Accepts write requests on wclk_i and drives the dual-port memory write port (address, enable, data).
- Maintains the binary and Gray write pointers and synchronises the read Gray pointer into wclk_i.
- Generates full, almost-full, occupancy and overflow-error status for the write agent.

Parameters:
- WIDTH, 8, data word width (matches `WIDTH).
- DEPTH, 16, FIFO entries; power of two, >= 4.
- ADDR, $clog2(DEPTH), memory address width. Derived; do not override.
- AF_MARGIN, 2, almost_full_o asserts when free entries <= AF_MARGIN; range 1..DEPTH-1.
- SYNC_STAGES, 2, flops in the rptr synchroniser; >= 2.

Ports:
- wclk_i  in  1  write clock; the only clock in the block.
- rst_i  in  1  synchronous, active-high reset.
- wr_en_i  in  1  write request.
- wdata_i  in  WIDTH  write data.
- rptr_gray_i  in  ADDR+1  read Gray pointer from the rclk domain; asynchronous to wclk_i.
- mem_we_o  out  1  memory write enable.
- waddr_o  out  ADDR  memory write address.
- mem_wdata_o  out  WIDTH  memory write data.
- wptr_gray_o  out  ADDR+1  registered write Gray pointer, sent to the read domain.
- full_o  out  1  FIFO full.
- almost_full_o  out  1  free entries <= AF_MARGIN.
- wcount_o  out  ADDR+1  occupancy as seen from the write domain (conservative).
- error_o  out  1  overflow pulse.

Behaviour:
- Reset (rst_i=1 at a wclk_i edge):
  - wptr_bin, wptr_gray_o, all synchroniser flops, wcount_o, full_o, almost_full_o and error_o go to 0.
  - mem_we_o is forced 0 combinationally while rst_i=1, so no write is performed in a reset cycle even if wr_en_i=1.
- Accept rule: push = wr_en_i & ~full_o & ~rst_i.
  - mem_we_o = push (combinational).
  - waddr_o = wptr_bin[ADDR-1:0].
  - mem_wdata_o = wdata_i (pass-through).
  - The memory captures on the same wclk_i edge, so write latency is 0 cycles to memory.
- Pointers are ADDR+1 bits wide.
  - wbin_next = wptr_bin + push, wrapping modulo 2^(ADDR+1).
  - wgray_next = wbin_next ^ (wbin_next >> 1).
  - Both are registered every edge. wptr_gray_o changes at most one bit per edge.
- Synchroniser: rptr_gray_i passes through SYNC_STAGES flops to give rq_gray. No other logic samples rptr_gray_i.
- full_o (registered): full_o <= (wgray_next == {~rq_gray[ADDR:ADDR-1], rq_gray[ADDR-2:0]}).
  - full_o asserts on the same edge that accepts the DEPTH-th outstanding entry.
- Occupancy:
  - rq_bin = Gray-to-binary(rq_gray).
  - wcount_o <= wbin_next - rq_bin, computed modulo 2^(ADDR+1), range 0..DEPTH.
  - almost_full_o <= (DEPTH - (wbin_next - rq_bin)) <= AF_MARGIN.
- Overflow:
  - error_o <= wr_en_i & full_o & ~rst_i, a one-cycle pulse per rejected write. A back-to-back rejected wr_en_i gives back-to-back pulses.
  - A rejected write leaves the pointers, the memory and wcount_o unchanged.
- Read-side release latency: a change on rptr_gray_i is reflected in full_o, almost_full_o and wcount_o after SYNC_STAGES+1 wclk_i edges. Status is pessimistic only; the block never reports fewer entries than are really held.
- Simultaneous write and read release in the same cycle:
  - push uses the registered full_o.
  - The new full_o accounts for both wbin_next and the latest rq_gray.
  - full_o may therefore hold steady across the cycle.
- Wrap-around:
  - waddr_o wraps from DEPTH-1 to 0.
  - The MSB of wptr_bin toggles every DEPTH pushes.
  - full versus empty is distinguished by the inverted top two Gray bits.
- Reset mid-operation: stored data is abandoned. The read domain must be reset coherently; this is outside the scope of this block.

Test Plan (DEPTH=16, AF_MARGIN=2, SYNC_STAGES=2, rptr_gray_i=0 unless stated):
- Reset: drive rst_i=1 with wr_en_i=1 for 2 edges.
  - mem_we_o must be 0 throughout.
  - After the release edge, wptr_gray_o=0, full_o=0, wcount_o=0 and error_o=0.
- Fill: apply 16 back-to-back writes of data 0x00..0x0F.
  - waddr_o steps 0..15.
  - almost_full_o rises on the edge accepting write 14 (wcount_o=14).
  - full_o rises on the 16th edge, with wcount_o=16 and wptr_gray_o=5'b11000.
- Overflow: while full, hold wr_en_i=1 for 3 cycles.
  - mem_we_o=0.
  - error_o is 1 for exactly 3 cycles.
  - wptr_gray_o stays 5'b11000 and wcount_o stays 16.
- Release: with full set, drive rptr_gray_i=5'b00001.
  - full_o falls and wcount_o becomes 15 exactly 3 edges later.
  - almost_full_o stays 1.
  - The next write is accepted at waddr_o=0.
- Wrap: stream 40 writes while rptr_gray_i follows wptr_gray_o with a 4-write lag.
  - full_o is never asserted.
  - waddr_o wraps 15->0 twice.
  - wptr_bin wraps 31->0 once.
  - The final wptr_gray_o equals the Gray code of 8 (5'b01100).
- Reset mid-fill: after 5 accepted writes, assert rst_i with wr_en_i=1 for 1 cycle.
  - No memory write occurs in that cycle.
  - On the next edge, all outputs are 0 and the following write goes to waddr_o=0.

Source files
------------

// File: rtl/fifo_wptr_full.sv
// Write-domain half of an asynchronous FIFO: write pointer, read-pointer
// synchroniser, and full / almost-full / occupancy / overflow status.
module fifo_wptr_full #(
    parameter int WIDTH       = 8,
    parameter int DEPTH       = 16,
    parameter int ADDR        = $clog2(DEPTH),
    parameter int AF_MARGIN   = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic             wclk_i,
    input  logic             rst_i,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [ADDR:0]    rptr_gray_i,
    output logic             mem_we_o,
    output logic [ADDR-1:0]  waddr_o,
    output logic [WIDTH-1:0] mem_wdata_o,
    output logic [ADDR:0]    wptr_gray_o,
    output logic             full_o,
    output logic             almost_full_o,
    output logic [ADDR:0]    wcount_o,
    output logic             error_o
);

    localparam logic [ADDR+1:0] DEPTH_W = (ADDR+2)'(DEPTH);
    localparam logic [ADDR+1:0] AF_W    = (ADDR+2)'(AF_MARGIN);

    logic [ADDR:0]                  wptr_bin;
    logic [SYNC_STAGES-1:0][ADDR:0] sync_q;
    logic [ADDR:0]                  rq_gray;
    logic [ADDR:0]                  rq_bin;
    logic [ADDR:0]                  wbin_next;
    logic [ADDR:0]                  wgray_next;
    logic [ADDR:0]                  full_gray;
    logic [ADDR:0]                  diff;
    logic [ADDR+1:0]                free;
    logic                           push;

    assign push        = wr_en_i & ~full_o & ~rst_i;
    assign mem_we_o    = push;
    assign waddr_o     = wptr_bin[ADDR-1:0];
    assign mem_wdata_o = wdata_i;

    assign rq_gray    = sync_q[SYNC_STAGES-1];
    assign wbin_next  = wptr_bin + {{ADDR{1'b0}}, push};
    assign wgray_next = wbin_next ^ (wbin_next >> 1);

    // Full when the write pointer is exactly one lap ahead of the read pointer.
    assign full_gray = {~rq_gray[ADDR:ADDR-1], rq_gray[ADDR-2:0]};

    always_comb begin
        rq_bin = '0;
        for (int i = 0; i <= ADDR; i++)
            rq_bin[i] = ^(rq_gray >> i);
    end

    assign diff = wbin_next - rq_bin;
    assign free = DEPTH_W - {1'b0, diff};

    always_ff @(posedge wclk_i) begin
        if (rst_i) begin
            wptr_bin      <= '0;
            wptr_gray_o   <= '0;
            sync_q        <= '0;
            full_o        <= 1'b0;
            almost_full_o <= 1'b0;
            wcount_o      <= '0;
            error_o       <= 1'b0;
        end else begin
            sync_q[0] <= rptr_gray_i;
            for (int s = 1; s < SYNC_STAGES; s++)
                sync_q[s] <= sync_q[s-1];
            wptr_bin      <= wbin_next;
            wptr_gray_o   <= wgray_next;
            full_o        <= (wgray_next == full_gray);
            almost_full_o <= (free <= AF_W);
            wcount_o      <= diff;
            error_o       <= wr_en_i & full_o;
        end
    end

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Directed bench for fifo_wptr_full: table-driven fill/overflow plus
// hand-written reset, release, wrap and mid-fill reset sequences.
module tb_fifo_wptr_full;

    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int ADDR  = 4;

    logic             wclk_i = 1'b0;
    logic             rst_i;
    logic             wr_en_i;
    logic [WIDTH-1:0] wdata_i;
    logic [ADDR:0]    rptr_gray_i;
    logic             mem_we_o;
    logic [ADDR-1:0]  waddr_o;
    logic [WIDTH-1:0] mem_wdata_o;
    logic [ADDR:0]    wptr_gray_o;
    logic             full_o;
    logic             almost_full_o;
    logic [ADDR:0]    wcount_o;
    logic             error_o;

    int checks   = 0;
    int failures = 0;

    fifo_wptr_full #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_MARGIN(2), .SYNC_STAGES(2)) dut (
        .wclk_i        (wclk_i),
        .rst_i         (rst_i),
        .wr_en_i       (wr_en_i),
        .wdata_i       (wdata_i),
        .rptr_gray_i   (rptr_gray_i),
        .mem_we_o      (mem_we_o),
        .waddr_o       (waddr_o),
        .mem_wdata_o   (mem_wdata_o),
        .wptr_gray_o   (wptr_gray_o),
        .full_o        (full_o),
        .almost_full_o (almost_full_o),
        .wcount_o      (wcount_o),
        .error_o       (error_o)
    );

    always #5 wclk_i = ~wclk_i;

    typedef struct {
        logic           wr_en;
        logic [7:0]     wdata;
        logic           exp_we;
        logic [3:0]     exp_waddr;
        logic [4:0]     exp_gray;
        logic           exp_full;
        logic           exp_af;
        logic [4:0]     exp_count;
        logic           exp_err;
    } vec_t;

    vec_t vecs[19];

    function automatic logic [4:0] g(input int b);
        logic [4:0] v;
        v = 5'(b);
        return v ^ (v >> 1);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge wclk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_i = 1'b1; wr_en_i = 1'b0; rptr_gray_i = '0;
        tick();
        rst_i = 1'b0;
    endtask

    initial begin
        rst_i = 1'b1; wr_en_i = 1'b1; wdata_i = '0; rptr_gray_i = '0;

        // 16 writes of 0x00..0x0F, then 3 rejected writes while full
        for (int i = 0; i < 16; i++)
            vecs[i] = '{1'b1, 8'(i), 1'b1, 4'(i), g(i+1), (i == 15),
                        (i >= 13), 5'(i+1), 1'b0};
        for (int i = 16; i < 19; i++)
            vecs[i] = '{1'b1, 8'hAA, 1'b0, 4'd0, 5'b11000, 1'b1, 1'b1, 5'd16, 1'b1};

        // reset held with wr_en high for two edges
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("reset_we", mem_we_o, 0);
            tick();
        end
        rst_i = 1'b0; wr_en_i = 1'b0;
        chk("reset_gray",  wptr_gray_o, 0);
        chk("reset_full",  full_o, 0);
        chk("reset_af",    almost_full_o, 0);
        chk("reset_count", wcount_o, 0);
        chk("reset_err",   error_o, 0);

        // table-driven fill and overflow
        foreach (vecs[i]) begin
            wr_en_i = vecs[i].wr_en;
            wdata_i = vecs[i].wdata;
            #1;
            chk($sformatf("v%0d_we", i), mem_we_o, vecs[i].exp_we);
            if (vecs[i].exp_we) begin
                chk($sformatf("v%0d_waddr", i), waddr_o, vecs[i].exp_waddr);
                chk($sformatf("v%0d_wdata", i), mem_wdata_o, vecs[i].wdata);
            end
            tick();
            chk($sformatf("v%0d_gray", i),  wptr_gray_o,   vecs[i].exp_gray);
            chk($sformatf("v%0d_full", i),  full_o,        vecs[i].exp_full);
            chk($sformatf("v%0d_af", i),    almost_full_o, vecs[i].exp_af);
            chk($sformatf("v%0d_count", i), wcount_o,      vecs[i].exp_count);
            chk($sformatf("v%0d_err", i),   error_o,       vecs[i].exp_err);
        end
        wr_en_i = 1'b0;
        tick();
        chk("ovf_err_drop", error_o, 0);

        // release one entry from the read side
        rptr_gray_i = 5'b00001;
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk($sformatf("rel_full_e%0d", k),  full_o,   (k < 3) ? 1 : 0);
            chk($sformatf("rel_count_e%0d", k), wcount_o, (k < 3) ? 16 : 15);
            chk($sformatf("rel_af_e%0d", k),    almost_full_o, 1);
        end
        wr_en_i = 1'b1; wdata_i = 8'h55;
        #1;
        chk("rel_we", mem_we_o, 1);
        chk("rel_waddr", waddr_o, 0);
        tick();
        wr_en_i = 1'b0;
        chk("rel_refull", full_o, 1);
        chk("rel_gray", wptr_gray_o, 5'b11001);

        // wrap: 40 writes with the read pointer lagging by 4
        do_reset();
        for (int i = 0; i < 40; i++) begin
            rptr_gray_i = g((i >= 4) ? i - 4 : 0);
            wr_en_i = 1'b1; wdata_i = 8'(i);
            #1;
            chk($sformatf("wrap%0d_we", i), mem_we_o, 1);
            chk($sformatf("wrap%0d_waddr", i), waddr_o, i % 16);
            tick();
            chk($sformatf("wrap%0d_full", i), full_o, 0);
        end
        wr_en_i = 1'b0;
        chk("wrap_final_gray", wptr_gray_o, 5'b01100);

        // reset in the middle of a fill
        do_reset();
        wr_en_i = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        chk("mid_count5", wcount_o, 5);
        rst_i = 1'b1;
        #1;
        chk("mid_rst_we", mem_we_o, 0);
        tick();
        rst_i = 1'b0;
        chk("mid_gray",  wptr_gray_o, 0);
        chk("mid_full",  full_o, 0);
        chk("mid_af",    almost_full_o, 0);
        chk("mid_count", wcount_o, 0);
        chk("mid_err",   error_o, 0);
        #1;
        chk("mid_next_we", mem_we_o, 1);
        chk("mid_next_waddr", waddr_o, 0);
        tick();
        wr_en_i = 1'b0;
        chk("mid_next_count", wcount_o, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected done");
        $fatal(1);
    end

endmodule
